shift_seq8: RTL and testbench
=============================

Name: shift_seq8

Overview:
Multi-cycle shift sequencer placed directly upstream of the 2-bit-shamt combinational shifter8 stage (LSL/LSR/ASR). It accepts one 8-bit operand with a shift amount of 0..7 and decomposes the shift into per-cycle steps of at most 3. Each step is applied to an internal working register, and the final result is presented with a one-cycle done pulse. It lets the shift datapath support full 3-bit shift amounts without widening the combinational shifter.

Parameters:
WIDTH, 8, operand and result width
SHAMT_W, 3, shift-amount width (maximum shift 2^SHAMT_W-1 = 7)
STEP_MAX, 3, maximum shift applied per cycle (the largest shifter8 shamt)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 NOP, 01 LSL, 10 LSR, 11 ASR; latched on accept
d_in  input  WIDTH  operand; latched on accept
shamt  input  SHAMT_W  total shift amount; latched on accept
busy  output  1  high while a request is in progress (state SHIFT)
done  output  1  one-cycle pulse; result valid on d_out
d_out  output  WIDTH  result register; holds its value until the next completion

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, d_out=0, working register=0, remaining count=0, latched op=00.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: latch op, d_in into the working register, and shamt into rem.
  - If rem=0 or op=NOP: go to DONE (no shift).
  - Otherwise: go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), on each edge:
  - step = min(rem, STEP_MAX).
  - Working register is shifted by step per the latched op:
    - LSL: zero-fill from the LSB.
    - LSR: zero-fill from the MSB.
    - ASR: replicate the sign bit (bit 7 of the current working value).
  - rem = rem - step.
  - If the new rem=0: go to DONE and load d_out with the shifted value on that same edge.
  - Otherwise: stay in SHIFT.
- DONE: done=1 for exactly one cycle, busy=0; the next edge returns to IDLE.
- NOP / zero-shift path: d_out loads d_in on the accept edge.
- Latency:
  - Let k = ceil(shamt/STEP_MAX), with k=0 for shamt=0 or NOP.
  - With accept at edge n, done is high in the cycle after edge n+k.
  - Examples: shamt 1-3 gives k=1; 4-6 gives k=2; 7 gives k=3 (steps 3,3,1).
- start while in SHIFT or DONE is ignored, with no queuing; the next request must be presented in IDLE.
- Inputs are sampled only at the accept edge. Later changes to op/d_in/shamt do not affect the in-flight operation.
- d_out changes only on a completion edge or on reset. It is stable between done pulses.
- Reset asserted mid-operation aborts immediately:
  - All state returns to reset values.
  - No done pulse is issued.
  - d_out is cleared to 0.

Test Plan:
1. Reset, then start with op=10 (LSR), d_in=0x3D, shamt=5 -> busy for 2 cycles; done pulses 1 cycle; d_out=0x01.
2. Start with op=11 (ASR), d_in=0x9C, shamt=5 -> k=2; d_out=0xFC. Sign fill must persist across both steps (3 then 2).
3. Start with op=01 (LSL), d_in=0x3D, shamt=7 -> k=3 (steps 3,3,1); d_out=0x80. done high only in the cycle after the third SHIFT edge.
4. Start with op=10, d_in=0xA5, shamt=0; then op=00, d_in=0x5A, shamt=6 -> each completes with k=0: busy never asserts; done in the cycle after accept; d_out=0xA5, then 0x5A.
5. Start LSR d_in=0xF0 shamt=6; one cycle later pulse start with LSL d_in=0x11 shamt=1; hold start high through DONE -> second request ignored; d_out=0x03; next accept occurs only after returning to IDLE.
6. Start ASR d_in=0x80 shamt=7; assert reset in the second SHIFT cycle -> busy, done, and d_out drop to 0 immediately (asynchronously); no done pulse; a subsequent LSR 0x80 shamt=7 gives d_out=0x01.

Source files
------------

// File: rtl/shift_seq8_if.sv
// Request/result bundle between a shift client and the shift_seq8 sequencer.
// The master issues start/op/d_in/shamt; the slave answers with busy/done/d_out.
interface shift_seq8_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   d_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   d_out;

  modport master (
    output start, op, d_in, shamt,
    input  busy, done, d_out
  );

  modport slave (
    input  start, op, d_in, shamt,
    output busy, done, d_out
  );
endinterface

// File: rtl/shift_seq8.sv
// Multi-cycle shift sequencer: splits a 0..7 shift into steps of at most STEP_MAX
// so the downstream combinational shifter only needs a narrow shift amount.
module shift_seq8 #(
  parameter int WIDTH    = 8,
  parameter int SHAMT_W  = 3,
  parameter int STEP_MAX = 3
) (
  input  logic         clk,
  input  logic         reset,
  shift_seq8_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LSL = 2'b01;
  localparam logic [1:0] OP_LSR = 2'b10;
  localparam logic [1:0] OP_ASR = 2'b11;
  localparam logic [SHAMT_W-1:0] STEP_LIM = SHAMT_W'(STEP_MAX);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   work_reg, work_next;
  logic [WIDTH-1:0]   d_out_reg, d_out_next;
  logic [SHAMT_W-1:0] rem_reg, rem_next;
  logic [1:0]         op_reg, op_next;
  logic [SHAMT_W-1:0] step;
  logic [WIDTH-1:0]   shifted;

  assign step = (rem_reg > STEP_LIM) ? STEP_LIM : rem_reg;

  // ASR fills from bit WIDTH-1 of the current working value, so sign persists across steps
  always_comb begin
    shifted = work_reg;
    case (op_reg)
      OP_LSL:  shifted = work_reg << step;
      OP_LSR:  shifted = work_reg >> step;
      OP_ASR:  shifted = $unsigned($signed(work_reg) >>> step);
      default: shifted = work_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      d_out_reg <= '0;
      rem_reg   <= '0;
      op_reg    <= OP_NOP;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      d_out_reg <= d_out_next;
      rem_reg   <= rem_next;
      op_reg    <= op_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    d_out_next = d_out_reg;
    rem_next   = rem_reg;
    op_next    = op_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          op_next   = bus.op;
          work_next = bus.d_in;
          rem_next  = bus.shamt;
          if (bus.shamt == '0 || bus.op == OP_NOP) begin
            state_next = DONE;
            d_out_next = bus.d_in;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_next = shifted;
        rem_next  = rem_reg - step;
        // Last step: publish the result on the same edge that enters DONE
        if (rem_reg == step) begin
          state_next = DONE;
          d_out_next = shifted;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy  = (state_reg == SHIFT);
  assign bus.done  = (state_reg == DONE);
  assign bus.d_out = d_out_reg;

endmodule

// File: tb/tb_shift_seq8.sv
// Directed self-checking bench for shift_seq8; outputs are sampled on the falling edge.
module tb_shift_seq8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  shift_seq8_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

  shift_seq8 #(.WIDTH(8), .SHAMT_W(3), .STEP_MAX(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for one accept edge, then scramble the inputs to prove they were latched
  task automatic req(input logic [1:0] o, input logic [7:0] d, input logic [2:0] s);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.d_in = d; bus.shamt = s;
    @(negedge clk);
    bus.start = 1'b0; bus.op = ~o; bus.d_in = ~d; bus.shamt = ~s;
    $display("req op=%b d_in=%h shamt=%0d accepted", o, d, s);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.d_in = 8'h00; bus.shamt = 3'd0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.d_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", bus.d_out); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b done=%b want 0 0", bus.busy, bus.done); end
    $display("reset checked");
  endtask

  task automatic test_lsr;
    req(2'b10, 8'h3D, 3'd5);
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (bus.busy !== (c < 2)) begin errors++; $display("FAIL lsr_busy c=%0d got %b want %b", c, bus.busy, c < 2); end
      checks++; if (bus.done !== (c == 2)) begin errors++; $display("FAIL lsr_done c=%0d got %b want %b", c, bus.done, c == 2); end
    end
    checks++; if (bus.d_out !== 8'h01) begin errors++; $display("FAIL lsr_dout got %h want 01", bus.d_out); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL lsr_done_pulse got %b want 0", bus.done); end
    checks++; if (bus.d_out !== 8'h01) begin errors++; $display("FAIL lsr_dout_hold got %h want 01", bus.d_out); end
    $display("LSR 3D>>5 d_out=%h", bus.d_out);
  endtask

  task automatic test_asr;
    req(2'b11, 8'h9C, 3'd5);
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (bus.busy !== (c < 2)) begin errors++; $display("FAIL asr_busy c=%0d got %b want %b", c, bus.busy, c < 2); end
      checks++; if (bus.done !== (c == 2)) begin errors++; $display("FAIL asr_done c=%0d got %b want %b", c, bus.done, c == 2); end
      if (c < 2) begin
        checks++; if (bus.d_out !== 8'h01) begin errors++; $display("FAIL asr_dout_stable c=%0d got %h want 01", c, bus.d_out); end
      end
    end
    checks++; if (bus.d_out !== 8'hFC) begin errors++; $display("FAIL asr_dout got %h want fc", bus.d_out); end
    $display("ASR 9C>>>5 d_out=%h", bus.d_out);
  endtask

  task automatic test_lsl_max;
    req(2'b01, 8'h3D, 3'd7);
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (bus.busy !== (c < 3)) begin errors++; $display("FAIL lsl_busy c=%0d got %b want %b", c, bus.busy, c < 3); end
      checks++; if (bus.done !== (c == 3)) begin errors++; $display("FAIL lsl_done c=%0d got %b want %b", c, bus.done, c == 3); end
    end
    checks++; if (bus.d_out !== 8'h80) begin errors++; $display("FAIL lsl_dout got %h want 80", bus.d_out); end
    $display("LSL 3D<<7 d_out=%h", bus.d_out);
  endtask

  task automatic test_zero_shift;
    req(2'b10, 8'hA5, 3'd0);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", bus.done); end
    checks++; if (bus.d_out !== 8'hA5) begin errors++; $display("FAIL zero_dout got %h want a5", bus.d_out); end
    @(negedge clk);
    req(2'b00, 8'h5A, 3'd6);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nop_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL nop_done got %b want 1", bus.done); end
    checks++; if (bus.d_out !== 8'h5A) begin errors++; $display("FAIL nop_dout got %h want 5a", bus.d_out); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL nop_done_pulse got %b want 0", bus.done); end
    $display("zero-shift and NOP d_out=%h", bus.d_out);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.d_in = 8'hF0; bus.shamt = 3'd6;
    @(negedge clk);
    bus.op = 2'b01; bus.d_in = 8'h11; bus.shamt = 3'd1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy0 got %b want 1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy1 got %b want 1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", bus.done); end
    checks++; if (bus.d_out !== 8'h03) begin errors++; $display("FAIL b2b_dout got %h want 03", bus.d_out); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%b done=%b want 0 0", bus.busy, bus.done); end
    checks++; if (bus.d_out !== 8'h03) begin errors++; $display("FAIL b2b_dout_hold got %h want 03", bus.d_out); end
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy got %b want 1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b want 1", bus.done); end
    checks++; if (bus.d_out !== 8'h22) begin errors++; $display("FAIL b2b_second_dout got %h want 22", bus.d_out); end
    $display("back-to-back d_out=%h", bus.d_out);
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    req(2'b11, 8'h80, 3'd7);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b want 1", bus.busy); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_clr got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done_clr got %b want 0", bus.done); end
    checks++; if (bus.d_out !== 8'h00) begin errors++; $display("FAIL abort_dout_clr got %h want 00", bus.d_out); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_quiet c=%0d busy=%b done=%b want 0 0", c, bus.busy, bus.done); end
    end
    req(2'b10, 8'h80, 3'd7);
    repeat (3) @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL abort_next_done got %b want 1", bus.done); end
    checks++; if (bus.d_out !== 8'h01) begin errors++; $display("FAIL abort_next_dout got %h want 01", bus.d_out); end
    $display("reset abort then LSR 80>>7 d_out=%h", bus.d_out);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lsr();
    test_asr();
    test_lsl_max();
    test_zero_shift();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
